cacheline_burst_adapter: RTL and testbench
==========================================

// Module: cacheline_burst_adapter
// PURPOSE
//   Bridges L2/LLC cacheline port (one 256-bit line per request) to physical-memory burst port
//   (4 x 64-bit beats per line). Narrowing counterpart of the word<->line bus adapter.
//   Reads: collects 4 beats into a line. Writes: serialises a line into 4 beats.
//   Sits between last-level cache miss/writeback path and pmem.
// PARAMETERS
//   s_offset   5    log2(line bytes); LINE_BITS = 8*2**s_offset = 256
//   BEAT_BITS  64   memory beat width; BEATS = LINE_BITS/BEAT_BITS = 4 (must be power of 2, >=2)
// PORTS
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          asynchronous, active-low reset
//   line_i     in   LINE_BITS  writeback line from cache, sampled when write_i accepted
//   line_o     out  LINE_BITS  assembled read line, valid when resp_o=1
//   address_i  in   32         line request address from cache
//   read_i     in   1          line read request, held by cache until resp_o
//   write_i    in   1          line write request, held by cache until resp_o
//   resp_o     out  1          one-cycle completion pulse to cache
//   burst_i    in   BEAT_BITS  read beat from memory, valid when resp_i=1 in RD
//   burst_o    out  BEAT_BITS  write beat to memory, consumed when resp_i=1 in WR
//   address_o  out  32         burst address to memory
//   read_o     out  1          burst read request
//   write_o    out  1          burst write request
//   resp_i     in   1          memory beat handshake, one beat per cycle it is high
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, beat counter=0, line buffer=0, addr reg=0; line_o=0,
//     resp_o=0, read_o=0, write_o=0, burst_o=0, address_o=0. Mid-burst reset aborts silently.
//   FSM: IDLE -> RD | WR -> DONE -> IDLE.
//   IDLE: write_i=1 -> latch line_i, addr = {address_i[31:s_offset], 0}, cnt=0, go WR.
//     else read_i=1 -> latch addr (aligned), cnt=0, go RD. write_i wins if both high.
//     resp_i ignored in IDLE.
//   RD: read_o=1, address_o=addr. Each cycle resp_i=1: buf[BEAT_BITS*cnt +: BEAT_BITS] <= burst_i,
//     cnt++. Gaps (resp_i=0) allowed; counter holds. On beat BEATS-1: read_o drops next cycle, go DONE.
//   WR: write_o=1, address_o=addr, burst_o = buf[BEAT_BITS*cnt +: BEAT_BITS] (combinational from cnt).
//     Each resp_i=1 advances cnt; after beat BEATS-1 go DONE.
//   DONE: resp_o=1 for exactly one cycle; read_o=write_o=0; resp_i ignored; always -> IDLE.
//     Cache drops request in the cycle after resp_o, so IDLE never re-triggers on a stale request.
//   Latency: min request-to-resp_o = 1 (accept) + BEATS + 1 (DONE) = 6 cycles with back-to-back resp_i.
//   line_o: driven from buffer; holds last read line until next RD beat overwrites it.
//     After a write, line_o shows written line (cache must ignore it).
//   cnt width log2(BEATS); wraps to 0 on final beat. Request changes while RD/WR are ignored.
// CONFIGURATION
//   WRAP_BURST_EN defined: reads are critical-beat-first. addr keeps address_i[s_offset-1:3]
//     (beat index), address_o presents it, cnt starts at that index and wraps mod BEATS.
//     Burst still ends after exactly BEATS beats; each beat lands at its true line position.
//     Writes unchanged (beat 0 first, aligned address).
//   WRAP_BURST_EN undefined: reads aligned, beat 0 first; address_i[s_offset-1:0] ignored.
// TESTING
//   Read, address_i=0x0000_1234, resp_i high 4 cycles, beats A0..A3 -> address_o=0x0000_1220,
//     line_o={A3,A2,A1,A0}, resp_o one pulse 6 cycles after read_i rose.
//   Write, line_i={D3,D2,D1,D0}, resp_i with 2-cycle gaps -> burst_o D0,D1,D2,D3 in order,
//     write_o high until last beat, one resp_o, read_o never high.
//   read_i and write_i both high in IDLE -> write burst only; read served after resp_o if still held.
//   rst low after beat 2 of read -> read_o/resp_o 0 immediately, line_o=0, next read restarts at beat 0.
//   resp_i pulses in IDLE and DONE -> no counter change, no extra resp_o, line_o unchanged.
//   WRAP_BURST_EN, read address_i=0x40 + 0x10 -> address_o=0x50, beats B0..B3 ->
//     line_o={B1,B0,B3,B2}.

Source files
------------

// File: rtl/cacheline_burst_adapter.sv
// Cacheline <-> memory burst adapter: one LINE_BITS line per cache request, BEATS beats per memory burst.
// Define WRAP_BURST_EN for critical-beat-first read bursts; writes are always aligned, beat 0 first.
module cacheline_burst_adapter #(
  parameter int unsigned s_offset  = 5,
  parameter int unsigned BEAT_BITS = 64,
  localparam int unsigned LINE_BITS = 8 * (2 ** s_offset),
  localparam int unsigned BEATS     = LINE_BITS / BEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINE_BITS-1:0] line_i,
  output logic [LINE_BITS-1:0] line_o,
  input  logic [31:0]          address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic                 resp_o,
  input  logic [BEAT_BITS-1:0] burst_i,
  output logic [BEAT_BITS-1:0] burst_o,
  output logic [31:0]          address_o,
  output logic                 read_o,
  output logic                 write_o,
  input  logic                 resp_i
);

  localparam int unsigned CW        = $clog2(BEATS);
  localparam int unsigned BYTE_BITS = $clog2(BEAT_BITS / 8);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
`ifdef WRAP_BURST_EN
  localparam logic [31:0] BEAT_MASK = ~((32'd1 << BYTE_BITS) - 32'd1);
`endif

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [31:0]          addr_q, addr_d;
  logic                 last_beat;

`ifdef WRAP_BURST_EN
  // Wrapped reads start mid-line, so burst length is tracked apart from the beat position.
  logic [CW-1:0]        num_q, num_d;
  assign last_beat = (num_q == CW'(BEATS - 1));
`else
  assign last_beat = (cnt_q == CW'(BEATS - 1));
`endif

  assign line_o = line_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    addr_d    = addr_q;
`ifdef WRAP_BURST_EN
    num_d     = num_q;
`endif
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;

    case (state_q)
      IDLE: begin
`ifdef WRAP_BURST_EN
        num_d = '0;
`endif
        if (write_i) begin
          line_d  = line_i;
          addr_d  = address_i & LINE_MASK;
          cnt_d   = '0;
          state_d = WR;
        end else if (read_i) begin
`ifdef WRAP_BURST_EN
          addr_d  = address_i & BEAT_MASK;
          cnt_d   = address_i[s_offset-1:BYTE_BITS];
`else
          addr_d  = address_i & LINE_MASK;
          cnt_d   = '0;
`endif
          state_d = RD;
        end
      end
      RD: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (resp_i) begin
          line_d[BEAT_BITS*cnt_q +: BEAT_BITS] = burst_i;
          cnt_d = cnt_q + CW'(1);
`ifdef WRAP_BURST_EN
          num_d = num_q + CW'(1);
`endif
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = line_q[BEAT_BITS*cnt_q +: BEAT_BITS];
        if (resp_i) begin
          cnt_d = cnt_q + CW'(1);
`ifdef WRAP_BURST_EN
          num_d = num_q + CW'(1);
`endif
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
`ifdef WRAP_BURST_EN
      num_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
`ifdef WRAP_BURST_EN
      num_q   <= num_d;
`endif
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed self-checking bench for cacheline_burst_adapter (default 256-bit line, 64-bit beats).
module tb_cacheline_burst_adapter;

  localparam logic [255:0] LA = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                                 64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
  localparam logic [255:0] LD = {64'hD3D3_0000_1111_0003, 64'hD2D2_0000_1111_0002,
                                 64'hD1D1_0000_1111_0001, 64'hD0D0_0000_1111_0000};
  localparam logic [255:0] LE = {64'hE3E3_5555_0000_0003, 64'hE2E2_5555_0000_0002,
                                 64'hE1E1_5555_0000_0001, 64'hE0E0_5555_0000_0000};
  localparam logic [255:0] LF = {64'hF3F3_7777_0000_0003, 64'hF2F2_7777_0000_0002,
                                 64'hF1F1_7777_0000_0001, 64'hF0F0_7777_0000_0000};
  localparam logic [255:0] LG = {64'h6363_0000_9999_0003, 64'h6262_0000_9999_0002,
                                 64'h6161_0000_9999_0001, 64'h6060_0000_9999_0000};
  localparam logic [255:0] LH = {64'h4343_2222_0000_0003, 64'h4242_2222_0000_0002,
                                 64'h4141_2222_0000_0001, 64'h4040_2222_0000_0000};
  localparam logic [255:0] LB = {64'hB3B3_B3B3_0000_0003, 64'hB2B2_B2B2_0000_0002,
                                 64'hB1B1_B1B1_0000_0001, 64'hB0B0_B0B0_0000_0000};
`ifdef WRAP_BURST_EN
  localparam logic [255:0] LB_EXP  = {LB[127:64], LB[63:0], LB[255:192], LB[191:128]};
  localparam logic [31:0]  LB_ADDR = 32'h0000_0050;
`else
  localparam logic [255:0] LB_EXP  = LB;
  localparam logic [31:0]  LB_ADDR = 32'h0000_0040;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  cacheline_burst_adapter #(.s_offset(5), .BEAT_BITS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory side of a read: gap idle cycles before every beat; resp_o must land in the 6th cycle with no gaps.
  task automatic do_read(input logic [31:0] a, input logic [31:0] ea, input logic [255:0] beats,
                         input int unsigned gap, input logic done_resp);
    read_i = 1'b1; address_i = a; resp_i = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("rd_req", 256'(read_o), 256'(1'b1));
      check("rd_addr", 256'(address_o), 256'(ea));
      check("rd_early_resp", 256'(resp_o), 256'(1'b0));
      for (int g = 0; g < int'(gap); g++) begin
        resp_i = 1'b0; burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(g);
        cyc();
        check("rd_gap_req", 256'(read_o), 256'(1'b1));
      end
      resp_i = 1'b1; burst_i = beats[64*i +: 64];
      cyc();
    end
    resp_i = done_resp; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    check("rd_resp", 256'(resp_o), 256'(1'b1));
    check("rd_done_req", 256'(read_o), 256'(1'b0));
    read_i = 1'b0;
    cyc();
    resp_i = 1'b0;
    check("rd_resp_pulse", 256'(resp_o), 256'(1'b0));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] ea, input logic [255:0] ln,
                          input int unsigned gap);
    write_i = 1'b1; address_i = a; line_i = ln; resp_i = 1'b0;
    cyc();
    line_i = ~ln;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g <= int'(gap); g++) begin
        resp_i = (g == int'(gap));
        check("wr_req", 256'(write_o), 256'(1'b1));
        check("wr_no_read", 256'(read_o), 256'(1'b0));
        check("wr_addr", 256'(address_o), 256'(ea));
        check("wr_beat", 256'(burst_o), 256'(ln[64*i +: 64]));
        check("wr_early_resp", 256'(resp_o), 256'(1'b0));
        cyc();
      end
    end
    resp_i = 1'b0;
    check("wr_resp", 256'(resp_o), 256'(1'b1));
    check("wr_done_req", 256'(write_o), 256'(1'b0));
    check("wr_done_no_read", 256'(read_o), 256'(1'b0));
    check("wr_line_o", line_o, ln);
    write_i = 1'b0;
    cyc();
    check("wr_resp_pulse", 256'(resp_o), 256'(1'b0));
    check("wr_idle_req", 256'(write_o), 256'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    @(negedge clk);
    check("rst_line_o", line_o, '0);
    check("rst_resp_o", 256'(resp_o), '0);
    check("rst_read_o", 256'(read_o), '0);
    check("rst_write_o", 256'(write_o), '0);
    check("rst_burst_o", 256'(burst_o), '0);
    check("rst_address_o", 256'(address_o), '0);
    cyc();
    rst = 1'b1;
    cyc();

    // aligned read, back-to-back beats
    do_read(32'h0000_1234, 32'h0000_1220, LA, 0, 1'b0);
    check("rd_line_a", line_o, LA);

    // write with 2-cycle gaps; line_o then shows the written line
    do_write(32'h0000_ABCD, 32'h0000_ABC0, LD, 2);

    // read and write together: write first, held read served afterwards
    read_i = 1'b1;
    do_write(32'h0000_2000, 32'h0000_2000, LE, 0);
    check("both_idle_read_o", 256'(read_o), '0);
    do_read(32'h0000_2000, 32'h0000_2000, LF, 1, 1'b1);
    check("rd_line_f", line_o, LF);

    // resp_i pulses while idle are ignored
    resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    check("idle_resp_o", 256'(resp_o), '0);
    check("idle_read_o", 256'(read_o), '0);
    cyc();
    check("idle_line_o", line_o, LF);
    resp_i = 1'b0;
    cyc();

    // reset after third beat of a read aborts it; retried read starts at beat 0
    read_i = 1'b1; address_i = 32'h0000_3000;
    cyc();
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = LG[64*i +: 64];
      cyc();
    end
    resp_i = 1'b0;
    check("mid_read_o", 256'(read_o), 256'(1'b1));
    rst = 1'b0;
    #1;
    check("arst_read_o", 256'(read_o), '0);
    check("arst_resp_o", 256'(resp_o), '0);
    check("arst_line_o", line_o, '0);
    check("arst_address_o", 256'(address_o), '0);
    cyc();
    rst = 1'b1;
    do_read(32'h0000_3000, 32'h0000_3000, LH, 0, 1'b0);
    check("rd_line_h", line_o, LH);

    // sub-line offset read: wrapped when WRAP_BURST_EN, aligned otherwise
    do_read(32'h0000_0050, LB_ADDR, LB, 0, 1'b0);
    check("rd_line_b", line_o, LB_EXP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
